// File: rtl/regfile_2r1w.sv
// Two-read, one-write integer register file.
// x0 reads as zero; write-through bypass; registered debug read.
module regfile_2r1w #(
  parameter int Width = 32,
  parameter int Depth = 32,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [AW-1:0]    a3,
  input  logic [Width-1:0] wd3,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  output logic [Width-1:0] rd1,
  output logic [Width-1:0] rd2,
  input  logic [AW-1:0]    dbg_a,
  output logic [Width-1:0] dbg_rd,
  output logic [15:0]      wr_cnt
);

  logic [Width-1:0] regs [1:Depth-1];

  logic             a3_ok;
  logic             byp_ok;
  logic             wr_en;
  logic [Width-1:0] mux1;
  logic [Width-1:0] mux2;
  logic [Width-1:0] mux_d;
  logic [Width-1:0] dbg_nxt;

  // write address names a stored register (never x0)
  always_comb begin
    a3_ok = 1'b0;
    for (int i = 1; i < Depth; i++) begin
      if (a3 == AW'(i)) a3_ok = 1'b1;
    end
  end

  // bypass ignores reset; commit does not
  assign byp_ok = we3 & a3_ok;
  assign wr_en  = rst_n & byp_ok;

  // stored-value read muxes; address 0 falls through to zero
  always_comb begin
    mux1  = '0;
    mux2  = '0;
    mux_d = '0;
    for (int i = 1; i < Depth; i++) begin
      if (a1 == AW'(i))    mux1  = regs[i];
      if (a2 == AW'(i))    mux2  = regs[i];
      if (dbg_a == AW'(i)) mux_d = regs[i];
    end
  end

  assign rd1 = (byp_ok && a1 == a3) ? wd3 : mux1;
  assign rd2 = (byp_ok && a2 == a3) ? wd3 : mux2;

  assign dbg_nxt = (wr_en && dbg_a == a3) ? wd3 : mux_d;

  // architectural state: reset clears, else commit one write
  always_ff @(posedge clk) begin
    for (int i = 1; i < Depth; i++) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (wr_en && a3 == AW'(i)) begin
        regs[i] <= wd3;
      end
    end
  end

  // debug read captures the post-write value
  always_ff @(posedge clk) begin
    if (!rst_n) dbg_rd <= '0;
    else        dbg_rd <= dbg_nxt;
  end

  // committed-write counter, free-running wrap
  always_ff @(posedge clk) begin
    if (!rst_n)     wr_cnt <= '0;
    else if (wr_en) wr_cnt <= wr_cnt + 16'd1;
  end

endmodule
